// File: rtl/fx_slave_regs.sv
// fx bus register-file slave: device-select decode, scratch and config bytes,
// command pulses, an atomic 64-bit status snapshot and a saturating event counter.
module fx_slave_regs #(
    parameter logic [5:0] DEV_ID  = 6'h00,
    parameter logic [7:0] VERSION = 8'h01
) (
    input  logic          clk_sys,
    input  logic          rst_n,
    input  logic [21:0]   fx_waddr,
    input  logic          fx_wr,
    input  logic [7:0]    fx_data,
    input  logic [21:0]   fx_raddr,
    input  logic          fx_rd,
    output logic [7:0]    fx_q,
    output logic [127:0]  cfg,
    output logic [7:0]    cmd_pulse,
    input  logic [63:0]   stat_in,
    input  logic          evt_in
);

    logic [7:0]  scratch_q, scratch_d;
    logic [7:0]  cmd_q, cmd_d;
    logic [55:0] shadow_q, shadow_d;
    logic [15:0] cnt_q, cnt_d;
    logic [7:0]  cnt_hi_q, cnt_hi_d;
    logic [7:0]  rdata_q, rdata_d;
    logic [7:0]  cfg_q [16];

    logic        wr_hit, rd_hit;
    logic [15:0] woff, roff;
    logic [15:0] cfg_we;
    logic [7:0]  stat_view [8];
    logic [7:0]  rd_byte;

    assign wr_hit = fx_wr && (fx_waddr[21:16] == DEV_ID);
    assign rd_hit = fx_rd && (fx_raddr[21:16] == DEV_ID);
    assign woff   = fx_waddr[15:0];
    assign roff   = fx_raddr[15:0];

    // Byte 0 of the status window is live; bytes 1-7 come from the snapshot.
    assign stat_view[0] = stat_in[7:0];

    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_cfg
            assign cfg_we[gi]          = wr_hit && (woff[15:4] == 12'h001) && (woff[3:0] == 4'(gi));
            assign cfg[8*gi +: 8]      = cfg_q[gi];
        end
        for (genvar gi = 1; gi < 8; gi++) begin : g_stat
            assign stat_view[gi] = shadow_q[8*(gi-1) +: 8];
        end
    endgenerate

    // Read mux sees pre-write state, so a same-cycle write/read returns the old value.
    always_comb begin
        rd_byte = 8'h00;
        if (roff == 16'h0000) begin
            rd_byte = VERSION;
        end else if (roff == 16'h0001) begin
            rd_byte = scratch_q;
        end else if (roff[15:4] == 12'h001) begin
            rd_byte = cfg_q[roff[3:0]];
        end else if (roff[15:3] == 13'h0004) begin
            rd_byte = stat_view[roff[2:0]];
        end else if (roff == 16'h0030) begin
            rd_byte = cnt_q[7:0];
        end else if (roff == 16'h0031) begin
            rd_byte = cnt_hi_q;
        end
    end

    always_comb begin
        scratch_d = scratch_q;
        cmd_d     = 8'h00;
        shadow_d  = shadow_q;
        cnt_hi_d  = cnt_hi_q;
        rdata_d   = rdata_q;
        cnt_d     = cnt_q;

        if (wr_hit && woff == 16'h0001) scratch_d = fx_data;
        if (wr_hit && woff == 16'h0002) cmd_d = fx_data;

        if (fx_rd) rdata_d = rd_hit ? rd_byte : 8'h00;
        if (rd_hit && roff == 16'h0020) shadow_d = stat_in[63:8];
        if (rd_hit && roff == 16'h0030) cnt_hi_d = cnt_q[15:8];

        // Clear takes priority over a coincident event.
        if (wr_hit && woff == 16'h0030) begin
            cnt_d = 16'h0000;
        end else if (evt_in && cnt_q != 16'hFFFF) begin
            cnt_d = cnt_q + 16'h0001;
        end
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            scratch_q <= 8'h00;
            cmd_q     <= 8'h00;
            shadow_q  <= 56'h0;
            cnt_q     <= 16'h0000;
            cnt_hi_q  <= 8'h00;
            rdata_q   <= 8'h00;
            for (int i = 0; i < 16; i++) cfg_q[i] <= 8'h00;
        end else begin
            scratch_q <= scratch_d;
            cmd_q     <= cmd_d;
            shadow_q  <= shadow_d;
            cnt_q     <= cnt_d;
            cnt_hi_q  <= cnt_hi_d;
            rdata_q   <= rdata_d;
            for (int i = 0; i < 16; i++) begin
                if (cfg_we[i]) cfg_q[i] <= fx_data;
            end
        end
    end

    assign fx_q      = rdata_q;
    assign cmd_pulse = cmd_q;

endmodule

// File: tb/tb_fx_slave_regs.sv
// Directed bench for fx_slave_regs (DEV_ID=5, VERSION=3A); inputs change on the
// falling edge and outputs are sampled on the falling edge.
module tb_fx_slave_regs;

    logic          clk_sys = 1'b0;
    logic          rst_n;
    logic [21:0]   fx_waddr;
    logic          fx_wr;
    logic [7:0]    fx_data;
    logic [21:0]   fx_raddr;
    logic          fx_rd;
    logic [7:0]    fx_q;
    logic [127:0]  cfg;
    logic [7:0]    cmd_pulse;
    logic [63:0]   stat_in;
    logic          evt_in;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk_sys = ~clk_sys;

    fx_slave_regs #(.DEV_ID(6'h05), .VERSION(8'h3A)) dut (
        .clk_sys  (clk_sys),
        .rst_n    (rst_n),
        .fx_waddr (fx_waddr),
        .fx_wr    (fx_wr),
        .fx_data  (fx_data),
        .fx_raddr (fx_raddr),
        .fx_rd    (fx_rd),
        .fx_q     (fx_q),
        .cfg      (cfg),
        .cmd_pulse(cmd_pulse),
        .stat_in  (stat_in),
        .evt_in   (evt_in)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic wr(input logic [21:0] a, input logic [7:0] d);
        @(negedge clk_sys);
        fx_waddr = a; fx_data = d; fx_wr = 1'b1;
        @(negedge clk_sys);
        fx_wr = 1'b0;
    endtask

    task automatic rd(input logic [21:0] a);
        @(negedge clk_sys);
        fx_raddr = a; fx_rd = 1'b1;
        @(negedge clk_sys);
        fx_rd = 1'b0;
    endtask

    logic [7:0] exp_sh [7];

    initial begin
        exp_sh = '{8'h77, 8'h66, 8'h55, 8'h44, 8'h33, 8'h22, 8'h11};
        rst_n = 1'b0; fx_waddr = '0; fx_wr = 1'b0; fx_data = '0;
        fx_raddr = '0; fx_rd = 1'b0; stat_in = '0; evt_in = 1'b0;
        repeat (3) @(negedge clk_sys);
        check("reset_fx_q", fx_q, 8'h00);
        check("reset_cfg", cfg, 128'h0);
        check("reset_cmd", cmd_pulse, 8'h00);
        rst_n = 1'b1;

        rd(22'h050000); check("version", fx_q, 8'h3A);
        repeat (3) @(negedge clk_sys);
        check("hold_no_rd", fx_q, 8'h3A);
        rd(22'h060000); check("read_miss", fx_q, 8'h00);
        rd(22'h050005); check("unmapped_rd", fx_q, 8'h00);

        wr(22'h050013, 8'hA5);
        check("cfg3_after_wr", cfg[31:24], 8'hA5);
        check("cfg_others", {cfg[127:32], cfg[23:0]}, 120'h0);
        rd(22'h050013); check("cfg3_readback", fx_q, 8'hA5);
        rd(22'h050010); check("cfg0_readback", fx_q, 8'h00);
        wr(22'h060013, 8'h5A);
        check("cfg_miss_wr", cfg, {96'h0, 8'hA5, 24'h0});

        wr(22'h050002, 8'h81);
        check("cmd_pulse_hi", cmd_pulse, 8'h81);
        @(negedge clk_sys);
        check("cmd_pulse_lo", cmd_pulse, 8'h00);
        rd(22'h050002); check("cmd_read", fx_q, 8'h00);

        stat_in = 64'h1122334455667788;
        rd(22'h050020); check("stat_b0", fx_q, 8'h88);
        stat_in = 64'h0;
        for (int k = 1; k < 8; k++) begin
            rd(22'h050020 + 22'(k));
            check($sformatf("stat_b%0d", k), fx_q, exp_sh[k-1]);
        end

        @(negedge clk_sys); evt_in = 1'b1;
        repeat (300) @(negedge clk_sys);
        evt_in = 1'b0;
        rd(22'h050030); check("cnt_lo_300", fx_q, 8'h2C);
        rd(22'h050031); check("cnt_hi_300", fx_q, 8'h01);

        evt_in = 1'b1;
        repeat (70000) @(negedge clk_sys);
        evt_in = 1'b0;
        rd(22'h050030); check("cnt_lo_sat", fx_q, 8'hFF);
        rd(22'h050031); check("cnt_hi_sat", fx_q, 8'hFF);

        @(negedge clk_sys);
        fx_waddr = 22'h050030; fx_data = 8'h00; fx_wr = 1'b1; evt_in = 1'b1;
        @(negedge clk_sys);
        fx_wr = 1'b0; evt_in = 1'b0;
        rd(22'h050030); check("cnt_clear_wins", fx_q, 8'h00);
        rd(22'h050031); check("cnt_hi_cleared", fx_q, 8'h00);

        wr(22'h050001, 8'h10);
        @(negedge clk_sys);
        fx_waddr = 22'h050001; fx_data = 8'h20; fx_wr = 1'b1;
        fx_raddr = 22'h050001; fx_rd = 1'b1;
        @(negedge clk_sys);
        fx_wr = 1'b0; fx_rd = 1'b0;
        check("wr_rd_old", fx_q, 8'h10);
        rd(22'h050001); check("wr_rd_new", fx_q, 8'h20);

        rd(22'h050000);
        wr(22'h050002, 8'hFF);
        check("pre_rst_cmd", cmd_pulse, 8'hFF);
        #2 rst_n = 1'b0;
        #1;
        check("async_fx_q", fx_q, 8'h00);
        check("async_cfg", cfg, 128'h0);
        check("async_cmd", cmd_pulse, 8'h00);
        @(negedge clk_sys); rst_n = 1'b1;
        rd(22'h050001); check("rst_scratch", fx_q, 8'h00);
        rd(22'h050021); check("rst_shadow", fx_q, 8'h00);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
